// File: rtl/sample_pingpong_buffer.sv
// Two-bank ping-pong sample buffer: the capture side fills one bank while the reader streams the other.
// Optional drop counter: define SAMPLE_BUF_DROP_CNT_EN to enable drop_count_o.
module sample_pingpong_buffer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                    sample_valid_i,
  output logic                    buffer_ready_o,
  output logic                    read_enable_o,
  input  logic                    read_ack_i,
  output logic [SAMPLE_WIDTH-1:0] ram_sample_o,
  output logic                    overflow_o,
  output logic [15:0]             drop_count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  // state       | meaning
  // RD_IDLE     | waiting for a FULL bank
  // RD_PREFETCH | RAM read of word 0 in flight
  // RD_STREAM   | ram_sample_o valid, advancing on read_ack_i
  typedef enum logic [1:0] {RD_IDLE, RD_PREFETCH, RD_STREAM} rd_state_e;
  typedef enum logic [1:0] {BANK_FREE, BANK_FILLING, BANK_FULL, BANK_READING} bank_state_e;

  bank_state_e             bank_q [2];
  bank_state_e             bank_d [2];
  rd_state_e               rd_state_q, rd_state_d;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q, rd_ptr_next;
  logic                    rd_bank_q, oldest_q;
  logic [SAMPLE_WIDTH-1:0] mem [2*DEPTH];
  logic [SAMPLE_WIDTH-1:0] ram_q;
  logic                    overflow_q;

  logic             filling_any, fill_bank, wr_en, wr_last, drop;
  logic             full_a, full_b, rd_pick, rd_start, xfer, rd_last;
  logic             rd_load;
  logic [PTR_W:0]   rd_addr;

  assign filling_any = (bank_q[0] == BANK_FILLING) || (bank_q[1] == BANK_FILLING);
  assign fill_bank   = (bank_q[1] == BANK_FILLING);
  assign wr_en       = sample_valid_i && filling_any;
  assign wr_last     = wr_en && (wr_ptr_q == PTR_W'(DEPTH - 1));
  assign drop        = sample_valid_i && !filling_any;

  assign full_a      = (bank_q[0] == BANK_FULL);
  assign full_b      = (bank_q[1] == BANK_FULL);
  assign rd_pick     = (full_a && full_b) ? oldest_q : full_b;
  assign rd_start    = (rd_state_q == RD_IDLE) && (full_a || full_b);
  assign xfer        = (rd_state_q == RD_STREAM) && read_ack_i;
  assign rd_last     = xfer && (rd_ptr_q == PTR_W'(DEPTH - 1));
  assign rd_ptr_next = rd_ptr_q + PTR_W'(1);

  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    if (rd_start) bank_d[rd_pick] = BANK_READING;
    if (rd_last)  bank_d[rd_bank_q] = BANK_FREE;
    if (wr_last) begin
      bank_d[fill_bank] = BANK_FULL;
      if (bank_q[~fill_bank] == BANK_FREE) bank_d[~fill_bank] = BANK_FILLING;
    end
    // a bank freed on an earlier edge picks up filling here, bank A first after reset
    if (!filling_any) begin
      if (bank_q[0] == BANK_FREE)      bank_d[0] = BANK_FILLING;
      else if (bank_q[1] == BANK_FREE) bank_d[1] = BANK_FILLING;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_load    = 1'b0;
    rd_addr    = '0;
    case (rd_state_q)
      RD_IDLE: if (rd_start) rd_state_d = RD_PREFETCH;
      RD_PREFETCH: begin
        rd_load    = 1'b1;
        rd_addr    = {rd_bank_q, {PTR_W{1'b0}}};
        rd_state_d = RD_STREAM;
      end
      RD_STREAM: begin
        if (rd_last) begin
          rd_state_d = RD_IDLE;
        end else if (xfer) begin
          rd_load = 1'b1;
          rd_addr = {rd_bank_q, rd_ptr_next};
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[{fill_bank, wr_ptr_q}] <= sample_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q[0]  <= BANK_FREE;
      bank_q[1]  <= BANK_FREE;
      rd_state_q <= RD_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_bank_q  <= 1'b0;
      oldest_q   <= 1'b0;
      ram_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      rd_state_q <= rd_state_d;
      overflow_q <= drop;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      // oldest_q only matters when both banks are FULL at once
      if (wr_last) oldest_q <= (bank_q[~fill_bank] == BANK_FULL) ? ~fill_bank : fill_bank;
      if (rd_start) begin
        rd_bank_q <= rd_pick;
        rd_ptr_q  <= '0;
      end else if (xfer) begin
        rd_ptr_q  <= rd_ptr_next;
      end
      if (rd_load) ram_q <= mem[rd_addr];
    end
  end

`ifdef SAMPLE_BUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= 16'd0;
    end else if (overflow_q && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = 16'd0;
`endif

  assign buffer_ready_o = (rd_state_q != RD_IDLE);
  assign read_enable_o  = (rd_state_q == RD_STREAM);
  assign ram_sample_o   = ram_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_sample_pingpong_buffer.sv
// Directed bench for sample_pingpong_buffer with DEPTH=4; inputs change and outputs are observed on the falling edge.
module tb_sample_pingpong_buffer;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b1;
  logic [W-1:0] sample_i = '0;
  logic         sample_valid_i = 1'b0;
  logic         read_ack_i = 1'b0;
  logic         buffer_ready_o, read_enable_o, overflow_o;
  logic [W-1:0] ram_sample_o;
  logic [15:0]  drop_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  sample_pingpong_buffer #(.SAMPLE_WIDTH(W), .DEPTH(D)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .buffer_ready_o (buffer_ready_o),
    .read_enable_o  (read_enable_o),
    .read_ack_i     (read_ack_i),
    .ram_sample_o   (ram_sample_o),
    .overflow_o     (overflow_o),
    .drop_count_o   (drop_count_o)
  );

  task automatic do_reset();
    sample_valid_i = 1'b0;
    read_ack_i     = 1'b0;
    rst_ni         = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic write_sample(input logic [W-1:0] v);
    sample_i       = v;
    sample_valid_i = 1'b1;
    @(negedge clk_i);
    sample_valid_i = 1'b0;
  endtask

  task automatic wait_stream(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (read_enable_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic collect(input int n, input int budget, output logic [W-1:0] vals [16],
                         output int got, output bit ovf);
    got = 0;
    ovf = 1'b0;
    for (int i = 0; i < 16; i++) vals[i] = '0;
    for (int i = 0; i < budget && got < n; i++) begin
      if (overflow_o) ovf = 1'b1;
      if (read_enable_o && read_ack_i) begin
        vals[got] = ram_sample_o;
        got++;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    checks += 5;
    if (buffer_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", buffer_ready_o); end
    if (read_enable_o !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b expected 0", read_enable_o); end
    if (ram_sample_o !== 16'h0) begin errors++; $display("FAIL reset_sample: got %h expected 0000", ram_sample_o); end
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow_o); end
    if (drop_count_o !== 16'h0) begin errors++; $display("FAIL reset_drop: got %h expected 0000", drop_count_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_basic_stream();
    bit ok;
    do_reset();
    read_ack_i = 1'b1;
    for (int i = 1; i <= 4; i++) write_sample(W'(i));
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (buffer_ready_o) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    checks += 2;
    if (ok !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", ok); end
    if (read_enable_o !== 1'b0) begin errors++; $display("FAIL basic_prefetch: got %b expected 0", read_enable_o); end
    @(negedge clk_i);
    for (int k = 0; k < 4; k++) begin
      checks += 3;
      if (read_enable_o !== 1'b1) begin errors++; $display("FAIL basic_rden[%0d]: got %b expected 1", k, read_enable_o); end
      if (buffer_ready_o !== 1'b1) begin errors++; $display("FAIL basic_hold_ready[%0d]: got %b expected 1", k, buffer_ready_o); end
      if (ram_sample_o !== W'(k + 1)) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", k, ram_sample_o, k + 1); end
      @(negedge clk_i);
    end
    checks += 2;
    if (read_enable_o !== 1'b0) begin errors++; $display("FAIL basic_end_rden: got %b expected 0", read_enable_o); end
    if (buffer_ready_o !== 1'b0) begin errors++; $display("FAIL basic_end_ready: got %b expected 0", buffer_ready_o); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] vals [16];
    logic [15:0]  exp_cnt;
    int got;
    bit ovf, early_ovf;
`ifdef SAMPLE_BUF_DROP_CNT_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    do_reset();
    early_ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      write_sample(W'(11 + i));
      if (overflow_o) early_ovf = 1'b1;
    end
    write_sample(W'(99));
    checks += 2;
    if (early_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", early_ovf); end
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", overflow_o); end
    @(negedge clk_i);
    checks += 5;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_single: got %b expected 0", overflow_o); end
    if (drop_count_o !== exp_cnt) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", drop_count_o, exp_cnt); end
    if (buffer_ready_o !== 1'b1) begin errors++; $display("FAIL ovf_ready: got %b expected 1", buffer_ready_o); end
    if (read_enable_o !== 1'b1) begin errors++; $display("FAIL ovf_rden: got %b expected 1", read_enable_o); end
    if (ram_sample_o !== W'(11)) begin errors++; $display("FAIL ovf_held: got %0d expected 11", ram_sample_o); end
    read_ack_i = 1'b1;
    collect(8, 40, vals, got, ovf);
    checks += 2;
    if (got !== 8) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 8", got); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_drain_ovf: got %b expected 0", ovf); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (vals[i] !== W'(11 + i)) begin errors++; $display("FAIL ovf_drain[%0d]: got %0d expected %0d", i, vals[i], 11 + i); end
    end
  endtask

  task automatic test_ack_toggle();
    int exp_v [7] = '{21, 22, 22, 23, 23, 24, 24};
    bit ack_v [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) write_sample(W'(21 + i));
    wait_stream(10, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL ack_start: got %b expected 1", ok); end
    for (int k = 0; k < 7; k++) begin
      checks += 2;
      if (read_enable_o !== 1'b1) begin errors++; $display("FAIL ack_rden[%0d]: got %b expected 1", k, read_enable_o); end
      if (ram_sample_o !== W'(exp_v[k])) begin errors++; $display("FAIL ack_data[%0d]: got %0d expected %0d", k, ram_sample_o, exp_v[k]); end
      read_ack_i = ack_v[k];
      @(negedge clk_i);
    end
    read_ack_i = 1'b0;
    checks += 2;
    if (read_enable_o !== 1'b0) begin errors++; $display("FAIL ack_end_rden: got %b expected 0", read_enable_o); end
    if (buffer_ready_o !== 1'b0) begin errors++; $display("FAIL ack_end_ready: got %b expected 0", buffer_ready_o); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vals [16];
    int got;
    bit ovf;
    do_reset();
    read_ack_i = 1'b1;
    fork
      begin
        // two idle cycles per bank cover the reader's IDLE + PREFETCH overhead
        for (int b = 0; b < 4; b++) begin
          for (int s = 0; s < 4; s++) write_sample(W'(b * 4 + s + 1));
          repeat (2) @(negedge clk_i);
        end
      end
      collect(16, 80, vals, got, ovf);
    join
    checks += 2;
    if (got !== 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", got); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", ovf); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (vals[i] !== W'(i + 1)) begin errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, vals[i], i + 1); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] vals [16];
    int got;
    bit ovf, ok;
    do_reset();
    read_ack_i = 1'b1;
    for (int i = 0; i < 6; i++) write_sample(W'(31 + i));
    wait_stream(10, ok);
    @(negedge clk_i);
    @(negedge clk_i);
    checks += 2;
    if (ok !== 1'b1) begin errors++; $display("FAIL mid_start: got %b expected 1", ok); end
    if (ram_sample_o !== W'(33)) begin errors++; $display("FAIL mid_ptr2: got %0d expected 33", ram_sample_o); end
    rst_ni = 1'b0;
    #1;
    checks += 5;
    if (buffer_ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", buffer_ready_o); end
    if (read_enable_o !== 1'b0) begin errors++; $display("FAIL mid_rden: got %b expected 0", read_enable_o); end
    if (ram_sample_o !== 16'h0) begin errors++; $display("FAIL mid_sample: got %h expected 0000", ram_sample_o); end
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", overflow_o); end
    if (drop_count_o !== 16'h0) begin errors++; $display("FAIL mid_drop: got %h expected 0000", drop_count_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) write_sample(W'(41 + i));
    collect(4, 20, vals, got, ovf);
    checks++;
    if (got !== 4) begin errors++; $display("FAIL mid_refill_count: got %0d expected 4", got); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vals[i] !== W'(41 + i)) begin errors++; $display("FAIL mid_refill[%0d]: got %0d expected %0d", i, vals[i], 41 + i); end
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0] pat [4] = '{16'h8000, 16'h7FFF, 16'h8001, 16'h7FFE};
    logic [W-1:0] vals [16];
    int got;
    bit ovf;
    do_reset();
    read_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) write_sample(pat[i]);
    collect(4, 20, vals, got, ovf);
    checks++;
    if (got !== 4) begin errors++; $display("FAIL ext_count: got %0d expected 4", got); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vals[i] !== pat[i]) begin errors++; $display("FAIL ext_data[%0d]: got %h expected %h", i, vals[i], pat[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_overflow();
    test_ack_toggle();
    test_back_to_back();
    test_reset_mid();
    test_extremes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
